// File: rtl/shift_add_multiplier.sv
// Iterative 32x32 signed shift-and-add multiplier for the execute stage.
// Operand magnitudes are multiplied over exactly 32 cycles. Each cycle the
// multiplicand magnitude is left-shifted by the iteration count, and the
// shifted value is accumulated when the matching multiplier bit is set. The
// sign is applied once, when the result is registered.
//
// Ports:
//   clock          system clock, rising-edge
//   reset          synchronous active-high reset, overrides ctrl_MULT
//   ctrl_MULT      start pulse; operands sampled on that edge (ignored in RUN)
//   data_operandA  multiplicand, two's complement
//   data_operandB  multiplier, two's complement
//   data_result    low WIDTH bits of A*B (registered; holds until next result)
//   data_exception product does not fit in signed WIDTH bits (registered)
//   data_resultRDY one-cycle pulse marking a new result/exception
//   busy           high while iterating
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             exc_q, exc_d;

  // Feed to the barrel left-shifter: data = magA, shamt = count.
  logic [CW-1:0]      shamt;
  logic [2*WIDTH-1:0] shift_full;
  logic [WIDTH-1:0]   shifted;
  logic               lost;
  logic [WIDTH:0]     sum;

  logic start;
  logic last_iter;

  assign shamt      = count_q;
  assign shift_full = {{WIDTH{1'b0}}, mag_a_q} << shamt;
  assign shifted    = shift_full[WIDTH-1:0];
  // Any bit pushed past the top of the shifter means the partial product overflows.
  assign lost       = |shift_full[2*WIDTH-1:WIDTH];
  assign sum        = {1'b0, acc_q} + {1'b0, shifted};

  assign start     = ctrl_MULT && (state_q != RUN);
  assign last_iter = (state_q == RUN) && (count_q == CW'(WIDTH - 1));

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      exc_q    <= exc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN:        state_d = last_iter ? DONE : RUN;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    count_d  = count_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;
    if (start) begin
      mag_a_d = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b_d = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (mag_b_q[count_q]) begin
        acc_d = sum[WIDTH-1:0];
        if (lost || sum[WIDTH]) ovf_d = 1'b1;
      end
      count_d = count_q + CW'(1);
      // Result is registered on the edge entering DONE, so it uses the
      // final accumulator value being computed this cycle.
      if (last_iter) begin
        result_d = neg_q ? -acc_d : acc_d;
        // A magnitude with the top bit set only fits as exactly -2^(WIDTH-1).
        exc_d    = ovf_d | (acc_d[WIDTH-1] & ~(neg_q & (acc_d == MIN_NEG)));
      end
    end
  end

  // Outputs
  always_comb begin
    busy           = (state_q == RUN);
    data_resultRDY = (state_q == DONE);
    data_result    = result_q;
    data_exception = exc_q;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_MULT(ctrl_MULT),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int rdy_count = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: true signed product and its fit in signed 32 bits.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pv;
    logic e;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    e  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return {e, pv[31:0]};
  endfunction

  // Timing model: edge counter, start edge s, result due 32 edges later.
  int cnt = 0;
  int s = 0;
  logic active = 1'b0;
  logic [31:0] pend_r = '0, held_r = '0;
  logic pend_e = 1'b0, held_e = 1'b0;

  always @(posedge clock) begin
    logic [32:0] m;
    cnt++;
    if (reset) begin
      active = 1'b0;
      held_r = '0;
      held_e = 1'b0;
    end else begin
      if (active && cnt == s + 32) begin
        held_r = pend_r;
        held_e = pend_e;
      end
      if (ctrl_MULT && !(active && cnt <= s + 32)) begin
        active = 1'b1;
        s = cnt;
        m = ref_mul(data_operandA, data_operandB);
        pend_r = m[31:0];
        pend_e = m[32];
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, active && cnt >= s && cnt < s + 32});
      chk("resultRDY", {31'b0, data_resultRDY}, {31'b0, active && cnt == s + 32});
      chk("result_model", data_result, held_r);
      chk("exception_model", {31'b0, data_exception}, {31'b0, held_e});
      if (data_resultRDY) rdy_count++;
    end
  end

  // Starts at a negedge; returns at the negedge where resultRDY is seen.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
    int lat;
    int nb;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 1;
    nb = 0;
    while (!data_resultRDY && lat < 40) begin
      if (busy) nb++;
      @(negedge clock);
      lat++;
    end
    chk({nm, "_latency"}, lat, 33);
    chk({nm, "_busy_cycles"}, nb, 32);
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exception"}, {31'b0, data_exception}, {31'b0, ee});
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exception", {31'b0, data_exception}, 32'h0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    do_op("3x4", 32'd3, 32'd4, 32'd12, 1'b0);
    @(negedge clock);
    do_op("m7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    do_op("6xm7", 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0);
    do_op("2p16sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    do_op("2p30x2", 32'h40000000, 32'd2, 32'h80000000, 1'b1);
    @(negedge clock);
    @(negedge clock);
    do_op("minx1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    do_op("minxm1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    do_op("maxx1", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
    do_op("ffffsq", 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1);
    do_op("zero", 32'd0, 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge clock);

    // ctrl_MULT during RUN must be ignored.
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    base = rdy_count;
    repeat (60) @(negedge clock);
    chk("run_ignore_rdy_pulses", rdy_count - base, 1);
    chk("run_ignore_result", data_result, 32'd25);

    // Start in IDLE, then a start issued during the DONE cycle.
    do_op("5x5", 32'd5, 32'd5, 32'd25, 1'b0);
    do_op("done_2x3", 32'd2, 32'd3, 32'd6, 1'b0);
    @(negedge clock);

    // Reset mid-run aborts without a result pulse.
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", data_result, 32'h0);
    chk("abort_exception", {31'b0, data_exception}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
    base = rdy_count;
    repeat (40) @(negedge clock);
    chk("abort_no_rdy", rdy_count - base, 0);

    do_op("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
